// File: rtl/conv_pack64.sv
// Packs four 16-bit stream words into one 64-bit beat and frames beats into packets with tlast.
// Optional partial-beat flush on input idle is enabled by defining PACK_FLUSH_EN.
module conv_pack64 #(
    parameter int PKT_BEATS     = 16,
    parameter int FLUSH_TIMEOUT = 64
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [15:0] in_tdata,
    input  logic        in_tvalid,
    output logic        in_tready,
    output logic [63:0] out_tdata,
    output logic [7:0]  out_tkeep,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic        out_tlast,
    output logic [15:0] pkt_count
);

    localparam logic [15:0] LAST_BEAT = 16'(PKT_BEATS - 1);

    // Empty block: only makes the timeout parameter visible to elaboration in every build.
    if (FLUSH_TIMEOUT < 2) begin : g_bad_flush_timeout
    end

    logic [1:0]  word_idx;
    logic [47:0] asm_data;
    logic [15:0] beat_cnt;
    logic        ready_en;

    logic out_free;
    logic in_hs;
    logic out_hs;
    logic load_full;
    logic beat_last;

    assign out_free  = ~out_tvalid | out_tready;
    assign in_tready = ready_en & ((word_idx != 2'd3) | out_free);
    assign in_hs     = in_tvalid & in_tready;
    assign out_hs    = out_tvalid & out_tready;
    assign load_full = in_hs & (word_idx == 2'd3);
    assign beat_last = (beat_cnt == LAST_BEAT);

`ifdef PACK_FLUSH_EN
    localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(FLUSH_TIMEOUT - 1);

    logic [TW-1:0] idle_timer;
    logic          flush;
    logic [63:0]   flush_data;
    logic [7:0]    flush_keep;

    // Input handshake always beats a pending flush; unfilled word slots read as zero.
    always_comb begin
        flush      = ~in_hs & (word_idx != 2'd0) & (idle_timer == TIMER_LAST) & out_free;
        flush_data = {16'h0000,
                      (word_idx == 2'd3) ? asm_data[47:32] : 16'h0000,
                      (word_idx >= 2'd2) ? asm_data[31:16] : 16'h0000,
                      (word_idx >= 2'd1) ? asm_data[15:0]  : 16'h0000};
        case (word_idx)
            2'd1:    flush_keep = 8'h03;
            2'd2:    flush_keep = 8'h0F;
            2'd3:    flush_keep = 8'h3F;
            default: flush_keep = 8'h00;
        endcase
    end

    // Timer saturates at expiry so a blocked flush fires on the first free output clock.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idle_timer <= '0;
        end else if (in_hs || flush || word_idx == 2'd0) begin
            idle_timer <= '0;
        end else if (idle_timer != TIMER_LAST) begin
            idle_timer <= idle_timer + 1'b1;
        end
    end
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            word_idx <= 2'd0;
            asm_data <= '0;
            beat_cnt <= '0;
        end else if (load_full) begin
            word_idx <= 2'd0;
            beat_cnt <= beat_last ? 16'd0 : beat_cnt + 16'd1;
        end else if (in_hs) begin
            asm_data[16*word_idx +: 16] <= in_tdata;
            word_idx <= word_idx + 2'd1;
`ifdef PACK_FLUSH_EN
        end else if (flush) begin
            word_idx <= 2'd0;
            beat_cnt <= '0;
`endif
        end
    end

    // Output register holds its beat until accepted; a new beat may load on the accepting clock.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_tdata  <= '0;
            out_tkeep  <= '0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
        end else if (load_full) begin
            out_tdata  <= {in_tdata, asm_data};
            out_tkeep  <= 8'hFF;
            out_tvalid <= 1'b1;
            out_tlast  <= beat_last;
`ifdef PACK_FLUSH_EN
        end else if (flush) begin
            out_tdata  <= flush_data;
            out_tkeep  <= flush_keep;
            out_tvalid <= 1'b1;
            out_tlast  <= 1'b1;
`endif
        end else if (out_hs) begin
            out_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_count <= '0;
        end else if (out_hs && out_tlast) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end

endmodule
